// File: rtl/sum_accumulator.sv
// Sequential N-bit summing controller driving an external combinational adder.
// Optional signed-overflow flag is built only when SUM_ACC_SIGNED_OVF_EN is defined.
module sum_accumulator #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   count,
  input  logic [N-1:0] op_data,
  input  logic         op_valid,
  output logic         op_ready,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic [N-1:0] result,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         flag_c,
  output logic         flag_z,
  output logic         flag_v,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] acc_q, acc_d;
  logic [3:0]   remaining_q, remaining_d;
  logic         flag_c_q, flag_c_d;
  logic         flag_z_q, flag_z_d;
  logic         accept;
  logic         launch;

  assign accept = op_valid && op_ready;
  assign launch = (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= 4'd0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (count == 4'd0) ? DONE : ACC;
      ACC:  if (accept && (remaining_q == 4'd1)) state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state_q == ACC);
    res_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // flag_z is registered so it only reports a zero sum once a run completes.
  always_comb begin
    acc_d       = acc_q;
    remaining_d = remaining_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    if (launch) begin
      acc_d       = '0;
      remaining_d = count;
      flag_c_d    = 1'b0;
      flag_z_d    = (count == 4'd0);
    end else if (accept) begin
      acc_d       = add_sum;
      remaining_d = remaining_q - 4'd1;
      flag_c_d    = flag_c_q | add_cout;
      flag_z_d    = (remaining_q == 4'd1) && (add_sum == '0);
    end
  end

`ifdef SUM_ACC_SIGNED_OVF_EN
  logic flag_v_q, flag_v_d;

  always_ff @(posedge clk) begin
    if (rst) flag_v_q <= 1'b0;
    else     flag_v_q <= flag_v_d;
  end

  // Overflow: operands of equal sign whose sum changes sign.
  always_comb begin
    flag_v_d = flag_v_q;
    if (launch) begin
      flag_v_d = 1'b0;
    end else if (accept) begin
      flag_v_d = flag_v_q |
                 ((acc_q[N-1] == op_data[N-1]) && (add_sum[N-1] != acc_q[N-1]));
    end
  end

  assign flag_v = flag_v_q;
`else
  assign flag_v = 1'b0;
`endif

  assign add_a  = acc_q;
  assign add_b  = op_data;
  assign result = acc_q;
  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand/accumulator width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new accumulation; sampled only in IDLE.
REQ-005 SHALL have port count  input  4  number of operands to sum; sampled with start.
REQ-006 SHALL have port op_data  input  N  operand value.
REQ-007 SHALL have port op_valid  input  1  op_data valid.
REQ-008 SHALL have port op_ready  output  1  block accepts an operand this cycle.
REQ-009 SHALL have port add_a  output  N  to adder A; driven with the accumulator register.
REQ-010 SHALL have port add_b  output  N  to adder B; driven with op_data.
REQ-011 SHALL have port add_sum  input  N  from adder Sum (combinational, same cycle).
REQ-012 SHALL have port add_cout  input  1  from adder Cout (same cycle).
REQ-013 SHALL have port result  output  N  final accumulated value.
REQ-014 SHALL have port res_valid  output  1  result and flags valid.
REQ-015 SHALL have port res_ready  input  1  consumer accepts result.
REQ-016 SHALL have ports flag_c, flag_z, flag_v  output  1 each  sticky carry, zero, signed overflow.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, ACC, DONE.
REQ-019 IDLE: start=1 and count!=0 -> acc<=0, remaining<=count, flags<=0, go to ACC next cycle.
REQ-020 IDLE: start=1 and count==0 -> acc<=0, flag_c<=0, flag_v<=0, go directly to DONE; result 0, flag_z=1.
REQ-021 ACC: op_ready=1; in all other states op_ready=0.
REQ-022 ACC: on op_valid&&op_ready -> acc<=add_sum, flag_c<=flag_c|add_cout, remaining<=remaining-1.
REQ-023 ACC: accepted transfer with remaining==1 -> go to DONE next cycle; no op_valid -> hold all state.
REQ-024 Accumulation SHALL wrap modulo 2^N; carry-out is recorded only through flag_c.
REQ-025 DONE: res_valid=1, result=acc, flag_z=(acc==0); outputs held stable until res_ready=1.
REQ-026 DONE with res_ready=1 -> IDLE next cycle; flags and result keep last values until next start.
REQ-027 start SHALL be ignored in ACC and DONE; start and res_ready same cycle in DONE -> only return to IDLE.
REQ-028 Latency: result valid exactly 1 cycle after the last accepted operand (count>=1), 1 cycle after start (count==0).
REQ-029 add_a/add_b SHALL be driven every cycle regardless of state.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, acc=0, remaining=0, result=0, all flags=0, res_valid=0, op_ready=0, busy=0.
REQ-031 rst SHALL take priority over every other input, including mid-ACC and in DONE; a partial sum is discarded.

Configuration
REQ-032 Macro SUM_ACC_SIGNED_OVF_EN defined: on each accepted operand flag_v<=flag_v|(acc[N-1]==op_data[N-1] && add_sum[N-1]!=acc[N-1]).
REQ-033 Macro SUM_ACC_SIGNED_OVF_EN undefined: flag_v SHALL be constant 0 and no overflow logic SHALL be built.

Verification (N=4)
REQ-034 start, count=3, operands 3,4,5 back-to-back, res_ready=1 -> result=12, flag_c=0, flag_z=0, res_valid 1 cycle after 5 accepted.
REQ-035 count=2, operands 9,9 -> result=2, flag_c=1, flag_z=0; with macro flag_v=1 (-7+-7).
REQ-036 count=2, operands 8,8 -> result=0, flag_c=1, flag_z=1; with macro flag_v=1, without flag_v=0.
REQ-037 start with count=0 -> next cycle res_valid=1, result=0, flag_z=1; res_ready held 0 for 5 cycles -> outputs stable, start pulses ignored.
REQ-038 count=4, op_valid gaps of 2 cycles between operands 1,1,1,1 -> op_ready stays 1 in ACC, result=4 only after 4th accept.
REQ-039 rst asserted after 2 of 3 operands accepted -> next cycle IDLE, busy=0, all outputs 0; new start count=1, operand 7 -> result=7.
